// File: rtl/mealy_pair_decoder.sv
// Receive side of the two-wire Mealy symbol line: frames on SYNC, strips the
// alternating phase code, deserialises WIDTH bits MSB-first and checks even parity.
module mealy_pair_decoder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             sym_en,
  input  logic             b1,
  input  logic             b2,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             err_parity,
  output logic             err_abort,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    HUNT,
    DATA,
    PARITY
  } state_t;

  state_t           state;
  logic             phase;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;

  logic is_sync;
  logic is_idle;
  logic data_bit;

  assign is_sync  = b1 & b2;
  assign is_idle  = ~b1 & ~b2;
  assign data_bit = b1 ^ phase;

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state      <= HUNT;
      phase      <= 1'b0;
      cnt        <= '0;
      shreg      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      err_parity <= 1'b0;
      err_abort  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      err_parity <= 1'b0;
      err_abort  <= 1'b0;
      if (sym_en) begin
        // SYNC (re)starts a frame from any state without reporting an error
        if (is_sync) begin
          state <= DATA;
          phase <= 1'b0;
          cnt   <= '0;
          shreg <= '0;
          busy  <= 1'b1;
        end else if (state != HUNT) begin
          if (is_idle) begin
            state     <= HUNT;
            cnt       <= '0;
            err_abort <= 1'b1;
            busy      <= 1'b0;
          end else begin
            phase <= ~phase;
            if (state == DATA) begin
              shreg <= {shreg[WIDTH-2:0], data_bit};
              cnt   <= cnt + CW'(1);
              if (cnt == CW'(WIDTH - 1)) begin
                state <= PARITY;
              end
            end else begin
              if ((^shreg) == data_bit) begin
                data_out   <= shreg;
                data_valid <= 1'b1;
              end else begin
                err_parity <= 1'b1;
              end
              state <= HUNT;
              cnt   <= '0;
              busy  <= 1'b0;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mealy_pair_decoder.sv
// Randomised bench for mealy_pair_decoder with a queue-based frame reference model.
module tb_mealy_pair_decoder;

  localparam int W = 8;

  logic         Clk = 1'b0;
  logic         reset;
  logic         sym_en;
  logic         b1;
  logic         b2;
  logic [W-1:0] data_out;
  logic         data_valid;
  logic         err_parity;
  logic         err_abort;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  // reference model state
  logic [W-1:0] m_data;
  bit           m_valid, m_perr, m_abort, m_busy, m_in_frame;
  int           m_phase;
  bit           m_bits[$];

  mealy_pair_decoder #(.WIDTH(W)) dut (
    .Clk        (Clk),
    .reset      (reset),
    .sym_en     (sym_en),
    .b1         (b1),
    .b2         (b2),
    .data_out   (data_out),
    .data_valid (data_valid),
    .err_parity (err_parity),
    .err_abort  (err_abort),
    .busy       (busy)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_data = '0; m_valid = 0; m_perr = 0; m_abort = 0; m_busy = 0;
    m_in_frame = 0; m_phase = 0;
    m_bits.delete();
  endtask

  task automatic model_step(input bit en, input bit x1, input bit x2);
    logic [W-1:0] w;
    int p;
    m_valid = 0; m_perr = 0; m_abort = 0;
    if (!en) return;
    if (x1 && x2) begin
      m_in_frame = 1; m_phase = 0;
      m_bits.delete();
    end else if (!x1 && !x2) begin
      if (m_in_frame) m_abort = 1;
      m_in_frame = 0;
    end else if (m_in_frame) begin
      p = int'(x1) ^ m_phase;
      m_phase ^= 1;
      if (m_bits.size() < W) begin
        m_bits.push_back(bit'(p));
      end else begin
        w = '0;
        foreach (m_bits[i]) w = (w << 1) | W'(m_bits[i]);
        if (($countones(w) % 2) == p) begin
          m_data = w; m_valid = 1;
        end else begin
          m_perr = 1;
        end
        m_in_frame = 0;
      end
    end
    m_busy = m_in_frame;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_data"},  32'(data_out),   32'(m_data));
    check({tag, "_valid"}, 32'(data_valid), 32'(m_valid));
    check({tag, "_perr"},  32'(err_parity), 32'(m_perr));
    check({tag, "_abort"}, 32'(err_abort),  32'(m_abort));
    check({tag, "_busy"},  32'(busy),       32'(m_busy));
  endtask

  // inputs change 1 time unit after the rising edge, outputs sampled likewise
  task automatic cycle(input bit en, input bit x1, input bit x2, input string tag);
    sym_en = en; b1 = x1; b2 = x2;
    @(posedge Clk);
    model_step(en, x1, x2);
    #1;
    check_outputs(tag);
  endtask

  task automatic gap(input int gap_max, input string tag);
    repeat ($urandom_range(0, gap_max)) cycle(1'b0, 1'($urandom), 1'($urandom), tag);
  endtask

  task automatic send_frame(input logic [W-1:0] word, input bit good, input int gap_max,
                            input string tag);
    bit ph;
    bit x1;
    ph = 0;
    cycle(1'b1, 1'b1, 1'b1, tag);
    for (int i = W - 1; i >= 0; i--) begin
      gap(gap_max, tag);
      x1 = word[i] ^ ph;
      cycle(1'b1, x1, ~x1, tag);
      ph = ~ph;
    end
    gap(gap_max, tag);
    x1 = (^word) ^ (good ? 1'b0 : 1'b1) ^ ph;
    cycle(1'b1, x1, ~x1, tag);
  endtask

  task automatic send_data(input int n, input string tag);
    bit x1;
    for (int i = 0; i < n; i++) begin
      x1 = 1'($urandom);
      cycle(1'b1, x1, ~x1, tag);
    end
  endtask

  task automatic apply_reset(input string tag);
    sym_en = 1'b1; b1 = 1'b1; b2 = 1'b0;
    reset = 1'b0;
    model_reset();
    #1;
    check_outputs({tag, "_async"});
    repeat (3) @(posedge Clk);
    #1;
    check_outputs(tag);
    reset = 1'b1;
  endtask

  initial begin
    int r;
    bit x1;
    reset = 1'b0; sym_en = 1'b0; b1 = 1'b0; b2 = 1'b0;
    model_reset();
    #1;
    check_outputs("por");
    repeat (2) @(posedge Clk);
    #1;
    reset = 1'b1;

    // scenario 1: data before SYNC ignored; reset mid-frame discards it
    send_data(5, "s1_pre");
    cycle(1'b1, 1'b1, 1'b1, "s1_sync");
    send_data(4, "s1_mid");
    apply_reset("s1_rst");
    check("s1_busy_after_rst", 32'(busy), 32'(0));
    send_data(3, "s1_post");

    // scenario 2: clean 0xA5 frame
    send_frame(8'hA5, 1'b1, 0, "s2");
    check("s2_word",  32'(data_out),   32'h0000_00A5);
    check("s2_pulse", 32'(data_valid), 32'(1));
    check("s2_busy",  32'(busy),       32'(0));
    cycle(1'b0, 1'b0, 1'b0, "s2_after");
    check("s2_pulse_end", 32'(data_valid), 32'(0));

    // scenario 3: bad parity keeps old word
    send_frame(8'hA5, 1'b0, 0, "s3");
    check("s3_perr", 32'(err_parity), 32'(1));
    check("s3_hold", 32'(data_out),   32'h0000_00A5);

    // scenario 4: abort then clean frame
    cycle(1'b1, 1'b1, 1'b1, "s4_sync");
    send_data(3, "s4_data");
    cycle(1'b1, 1'b0, 1'b0, "s4_idle");
    check("s4_abort", 32'(err_abort), 32'(1));
    check("s4_busy",  32'(busy),      32'(0));
    send_frame(8'hA5, 1'b1, 0, "s4_clean");
    check("s4_word", 32'(data_out), 32'h0000_00A5);

    // scenario 5: SYNC restart mid-frame
    cycle(1'b1, 1'b1, 1'b1, "s5_sync");
    send_data(4, "s5_data");
    send_frame(8'h3C, 1'b1, 0, "s5");
    check("s5_word",  32'(data_out),   32'h0000_003C);
    check("s5_pulse", 32'(data_valid), 32'(1));

    // scenario 6: gaps, then back-to-back frame
    send_frame(8'hA5, 1'b1, 3, "s6a");
    check("s6_word", 32'(data_out), 32'h0000_00A5);
    send_frame(8'h5E, 1'b1, 0, "s6b");
    check("s6_b2b_word", 32'(data_out), 32'h0000_005E);

    // randomised frames
    for (int i = 0; i < 60; i++) begin
      send_frame(W'($urandom), ($urandom_range(0, 3) != 0), 2, "rfrm");
    end

    // randomised symbol soup with occasional resets
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 999);
      if (r < 3) begin
        apply_reset("rrst");
      end else if (r < 100) begin
        cycle(1'b0, 1'($urandom), 1'($urandom), "rnd_off");
      end else if (r < 140) begin
        cycle(1'b1, 1'b0, 1'b0, "rnd_idle");
      end else if (r < 200) begin
        cycle(1'b1, 1'b1, 1'b1, "rnd_sync");
      end else begin
        x1 = 1'($urandom);
        cycle(1'b1, x1, ~x1, "rnd_data");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
